// File: rtl/wb_adder_master.sv
// Pipelined Wishbone master for the adder peripheral: writes {b,a} to the operand
// register, reads the 9-bit sum back, and returns it with a timeout error flag.
module wb_adder_master #(
  parameter logic [31:0] BASE_ADDRESS   = 32'h3000_0000,
  parameter logic [31:0] INPUT_ADDRESS  = BASE_ADDRESS,
  parameter logic [31:0] OUTPUT_ADDRESS = BASE_ADDRESS + 32'd4,
  parameter int unsigned TIMEOUT        = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_op_valid,
  output logic        o_op_ready,
  input  logic [7:0]  i_op_a,
  input  logic [7:0]  i_op_b,
  output logic        o_res_valid,
  input  logic        i_res_ready,
  output logic [8:0]  o_res_sum,
  output logic        o_res_err,
  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  output logic        o_wb_we,
  output logic [31:0] o_wb_addr,
  output logic [31:0] o_wb_data,
  input  logic        i_wb_ack,
  input  logic        i_wb_stall,
  input  logic [31:0] i_wb_data
);

  localparam int unsigned   TW         = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_WAIT = 3'd2,
    RD_REQ  = 3'd3,
    RD_WAIT = 3'd4,
    RESP    = 3'd5
  } state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic          in_req_c;
  logic          in_wait_c;
  logic          accept_c;
  logic          done_c;
  logic          expire_c;
  logic          unused_rd_bits;

  // Bus events for the current access; an ack on the acceptance cycle completes it too.
  always_comb begin
    in_req_c  = (state == WR_REQ) || (state == RD_REQ);
    in_wait_c = (state == WR_WAIT) || (state == RD_WAIT);
    accept_c  = in_req_c && o_wb_stb && !i_wb_stall;
    done_c    = i_wb_ack && (accept_c || in_wait_c);
    expire_c  = (in_req_c || in_wait_c) && (timer == TIMER_LAST) && !done_c;
  end

  assign unused_rd_bits = ^i_wb_data[31:9];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      timer       <= '0;
      o_op_ready  <= 1'b1;
      o_res_valid <= 1'b0;
      o_res_sum   <= '0;
      o_res_err   <= 1'b0;
      o_wb_cyc    <= 1'b0;
      o_wb_stb    <= 1'b0;
      o_wb_we     <= 1'b0;
      o_wb_addr   <= '0;
      o_wb_data   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_op_valid && o_op_ready) begin
            state      <= WR_REQ;
            timer      <= '0;
            o_op_ready <= 1'b0;
            o_wb_cyc   <= 1'b1;
            o_wb_stb   <= 1'b1;
            o_wb_we    <= 1'b1;
            o_wb_addr  <= INPUT_ADDRESS;
            o_wb_data  <= {16'h0, i_op_b, i_op_a};
          end
        end
        WR_REQ, WR_WAIT, RD_REQ, RD_WAIT: begin
          if (done_c && (state == WR_REQ || state == WR_WAIT)) begin
            // Write done: issue the sum read while keeping cyc asserted.
            state     <= RD_REQ;
            timer     <= '0;
            o_wb_stb  <= 1'b1;
            o_wb_we   <= 1'b0;
            o_wb_addr <= OUTPUT_ADDRESS;
            o_wb_data <= '0;
          end else if (done_c) begin
            state       <= RESP;
            o_wb_cyc    <= 1'b0;
            o_wb_stb    <= 1'b0;
            o_res_valid <= 1'b1;
            o_res_sum   <= i_wb_data[8:0];
            o_res_err   <= 1'b0;
          end else if (expire_c) begin
            state       <= RESP;
            o_wb_cyc    <= 1'b0;
            o_wb_stb    <= 1'b0;
            o_res_valid <= 1'b1;
            o_res_sum   <= '0;
            o_res_err   <= 1'b1;
          end else begin
            timer <= timer + TW'(1);
            if (accept_c) begin
              o_wb_stb <= 1'b0;
              state    <= (state == WR_REQ) ? WR_WAIT : RD_WAIT;
            end
          end
        end
        RESP: begin
          if (i_res_ready) begin
            state       <= IDLE;
            o_res_valid <= 1'b0;
            o_op_ready  <= 1'b1;
          end
        end
        default: begin
          state      <= IDLE;
          o_op_ready <= 1'b1;
          o_wb_cyc   <= 1'b0;
          o_wb_stb   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_adder_master.sv
// Directed bench for wb_adder_master with a behavioural adder slave (stall, base
// address and stray-ack controls) plus table vectors and multi-cycle sequences.
module tb_wb_adder_master;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        op_valid;
  logic        op_ready;
  logic [7:0]  op_a;
  logic [7:0]  op_b;
  logic        res_valid;
  logic        res_ready;
  logic [8:0]  res_sum;
  logic        res_err;
  logic        wb_cyc;
  logic        wb_stb;
  logic        wb_we;
  logic [31:0] wb_addr;
  logic [31:0] wb_wdata;
  logic        wb_ack;
  logic        wb_stall;
  logic [31:0] wb_rdata;

  logic [31:0] slave_base = 32'h3000_0000;
  int          stall_req  = 0;
  int          stall_cnt  = 0;
  int          wr_accepts = 0;
  logic        slave_ack  = 1'b0;
  logic        stray_ack  = 1'b0;
  logic [15:0] op_reg     = 16'h0;
  logic [31:0] rd_data    = 32'h0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_adder_master dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_op_valid  (op_valid),
    .o_op_ready  (op_ready),
    .i_op_a      (op_a),
    .i_op_b      (op_b),
    .o_res_valid (res_valid),
    .i_res_ready (res_ready),
    .o_res_sum   (res_sum),
    .o_res_err   (res_err),
    .o_wb_cyc    (wb_cyc),
    .o_wb_stb    (wb_stb),
    .o_wb_we     (wb_we),
    .o_wb_addr   (wb_addr),
    .o_wb_data   (wb_wdata),
    .i_wb_ack    (wb_ack),
    .i_wb_stall  (wb_stall),
    .i_wb_data   (wb_rdata)
  );

  // Adder slave: stalls writes stall_req cycles, acks one cycle after acceptance.
  assign wb_stall = wb_cyc & wb_stb & wb_we & (stall_cnt < stall_req);
  assign wb_ack   = slave_ack | stray_ack;
  assign wb_rdata = rd_data;

  always @(posedge clk) begin
    slave_ack <= 1'b0;
    if (wb_cyc && wb_stb && wb_stall) stall_cnt <= stall_cnt + 1;
    else stall_cnt <= 0;
    if (wb_cyc && wb_stb && !wb_stall) begin
      if (wb_we) wr_accepts <= wr_accepts + 1;
      if (wb_addr == slave_base || wb_addr == slave_base + 32'd4) begin
        slave_ack <= 1'b1;
        if (wb_we) op_reg <= wb_wdata[15:0];
        else rd_data <= {16'hDEAD, 7'h55, 9'(op_reg[7:0]) + 9'(op_reg[15:8])};
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // One full operation; returns result plus observed latency and bus activity.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                        output logic [8:0] sum, output logic err,
                        output int lat, output int cyc_n, output int wr_n, output int bad_n);
    @(negedge clk);
    op_valid = 1'b1; op_a = a; op_b = b;
    lat = 0; cyc_n = 0; wr_n = 0; bad_n = 0;
    do begin
      @(negedge clk);
      lat++;
      op_valid = 1'b0;
      if (wb_cyc) cyc_n++;
      if (wb_stb && wb_we) begin
        wr_n++;
        if (wb_addr !== 32'h3000_0000 || wb_wdata !== {16'h0, b, a}) bad_n++;
      end
      if (wb_stb && !wb_we && (wb_addr !== 32'h3000_0004 || wb_wdata !== 32'h0)) bad_n++;
    end while (!res_valid && lat < 100);
    sum = res_sum;
    err = res_err;
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    int          stall;
    logic [31:0] base;
    logic [8:0]  sum;
    logic        err;
    int          lat;
    int          cyc;
    int          wr;
  } vec_t;

  vec_t        vecs [7];
  logic [8:0]  r_sum;
  logic        r_err;
  int          r_lat, r_cyc, r_wr, r_bad, wr0, n;

  initial begin
    vecs[0] = '{8'h12, 8'h34, 0, 32'h3000_0000, 9'h046, 1'b0,  5,  4, 1};
    vecs[1] = '{8'hFF, 8'hFF, 0, 32'h3000_0000, 9'h1FE, 1'b0,  5,  4, 1};
    vecs[2] = '{8'h00, 8'h00, 0, 32'h3000_0000, 9'h000, 1'b0,  5,  4, 1};
    vecs[3] = '{8'h80, 8'h7F, 3, 32'h3000_0000, 9'h0FF, 1'b0,  8,  7, 4};
    vecs[4] = '{8'h01, 8'hFF, 0, 32'h3000_0000, 9'h100, 1'b0,  5,  4, 1};
    vecs[5] = '{8'h05, 8'h06, 0, 32'h4000_0000, 9'h000, 1'b1, 17, 16, 1};
    vecs[6] = '{8'h55, 8'hAA, 0, 32'h3000_0000, 9'h0FF, 1'b0,  5,  4, 1};

    reset_n = 1'b0; op_valid = 1'b0; op_a = 8'h0; op_b = 8'h0; res_ready = 1'b0;
    #1;
    check("rst_cyc", 32'(wb_cyc), 32'd0);
    check("rst_stb", 32'(wb_stb), 32'd0);
    check("rst_we", 32'(wb_we), 32'd0);
    check("rst_addr", wb_addr, 32'h0);
    check("rst_data", wb_wdata, 32'h0);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_res_sum", 32'(res_sum), 32'd0);
    check("rst_res_err", 32'(res_err), 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_op_ready", 32'(op_ready), 32'd1);

    // Stray ack while idle must not start anything.
    stray_ack = 1'b1;
    @(negedge clk);
    stray_ack = 1'b0;
    @(negedge clk);
    check("stray_idle_cyc", 32'(wb_cyc), 32'd0);
    check("stray_idle_valid", 32'(res_valid), 32'd0);

    for (int i = 0; i < 7; i++) begin
      slave_base = vecs[i].base;
      stall_req  = vecs[i].stall;
      wr0        = wr_accepts;
      check($sformatf("v%0d_op_ready_before", i), 32'(op_ready), 32'd1);
      run_op(vecs[i].a, vecs[i].b, r_sum, r_err, r_lat, r_cyc, r_wr, r_bad);
      check($sformatf("v%0d_sum", i), 32'(r_sum), 32'(vecs[i].sum));
      check($sformatf("v%0d_err", i), 32'(r_err), 32'(vecs[i].err));
      check($sformatf("v%0d_latency", i), 32'(r_lat), 32'(vecs[i].lat));
      check($sformatf("v%0d_cyc_cycles", i), 32'(r_cyc), 32'(vecs[i].cyc));
      check($sformatf("v%0d_wr_stb_cycles", i), 32'(r_wr), 32'(vecs[i].wr));
      check($sformatf("v%0d_bus_fields", i), 32'(r_bad), 32'd0);
      check($sformatf("v%0d_wr_accepts", i), 32'(wr_accepts - wr0), 32'd1);
      check($sformatf("v%0d_valid_after", i), 32'(res_valid), 32'd0);
      check($sformatf("v%0d_op_ready_after", i), 32'(op_ready), 32'd1);
    end
    stall_req  = 0;
    slave_base = 32'h3000_0000;

    // Result held in RESP while consumer is not ready; new operands refused.
    @(negedge clk);
    op_valid = 1'b1; op_a = 8'h20; op_b = 8'h22;
    @(negedge clk);
    op_valid = 1'b0;
    n = 0;
    while (!res_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("hold_reached", 32'(res_valid), 32'd1);
    wr0 = wr_accepts;
    op_valid = 1'b1; op_a = 8'h01; op_b = 8'h02;
    for (int c = 0; c < 5; c++) begin
      stray_ack = (c == 2);
      @(negedge clk);
      check($sformatf("hold%0d_valid", c), 32'(res_valid), 32'd1);
      check($sformatf("hold%0d_sum", c), 32'(res_sum), 32'h042);
      check($sformatf("hold%0d_op_ready", c), 32'(op_ready), 32'd0);
      check($sformatf("hold%0d_cyc", c), 32'(wb_cyc), 32'd0);
    end
    stray_ack = 1'b0;
    op_valid  = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check("hold_valid_drop", 32'(res_valid), 32'd0);
    check("hold_op_ready", 32'(op_ready), 32'd1);
    check("hold_no_new_write", 32'(wr_accepts - wr0), 32'd0);

    // Reset asserted while waiting for the read ack.
    @(negedge clk);
    op_valid = 1'b1; op_a = 8'h0F; op_b = 8'h01;
    repeat (4) begin
      @(negedge clk);
      op_valid = 1'b0;
    end
    check("rdwait_cyc", 32'(wb_cyc), 32'd1);
    check("rdwait_stb", 32'(wb_stb), 32'd0);
    check("rdwait_we", 32'(wb_we), 32'd0);
    reset_n = 1'b0;
    #1;
    check("midrst_cyc", 32'(wb_cyc), 32'd0);
    check("midrst_stb", 32'(wb_stb), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("postrst_op_ready", 32'(op_ready), 32'd1);
    check("postrst_valid", 32'(res_valid), 32'd0);
    check("postrst_cyc", 32'(wb_cyc), 32'd0);
    run_op(8'h33, 8'h44, r_sum, r_err, r_lat, r_cyc, r_wr, r_bad);
    check("postrst_sum", 32'(r_sum), 32'h077);
    check("postrst_err", 32'(r_err), 32'd0);
    check("postrst_latency", 32'(r_lat), 32'd5);
    check("postrst_bus_fields", 32'(r_bad), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
